// File: rtl/fetch_ctrl.sv
// Instruction fetch sequencer: owns the PC, runs the single-beat imem handshake and
// holds each fetched word until decode accepts it. Optional macro: FETCH_ILLEGAL_CHECK_EN.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_insn,
  output logic [31:0] out_pc,
  output logic        out_illegal
);

  typedef enum logic {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } state_t;

  localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

  state_t      state;
  logic [31:0] pc;
  logic        transfer;
  logic        handshake;

  // The memory is stateless, so a beat exists only while our request is up.
  assign transfer  = (state == FETCH) && imem_req && imem_ack;
  assign handshake = (state == HOLD) && out_valid && out_ready;

  assign imem_addr = pc;

  // NOTE: all state uses non-blocking assignments so every register samples
  // the pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FETCH;
      pc        <= RESET_PC & WORD_MASK;
      imem_req  <= 1'b0;
      out_valid <= 1'b0;
      out_insn  <= '0;
      out_pc    <= '0;
    end else if (redirect) begin
      // Any beat or handshake landing with the redirect is dropped on the fetch side.
      state     <= FETCH;
      pc        <= redirect_pc & WORD_MASK;
      imem_req  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          if (transfer) begin
            out_insn  <= imem_rdata;
            out_pc    <= pc;
            out_valid <= 1'b1;
            pc        <= pc + 32'd4;
            imem_req  <= 1'b0;
            state     <= HOLD;
          end else begin
            imem_req  <= 1'b1;
          end
        end
        HOLD: begin
          if (handshake) begin
            out_valid <= 1'b0;
            imem_req  <= 1'b1;
            state     <= FETCH;
          end
        end
      endcase
    end
  end

`ifdef FETCH_ILLEGAL_CHECK_EN
  // Flag is captured with the word it describes and held with it until handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_illegal <= 1'b0;
    end else if (!redirect && transfer) begin
      out_illegal <= (imem_rdata[1:0] != 2'b11);
    end
  end
`else
  assign out_illegal = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: startup sequencing, stall, redirects, PC wrap,
// illegal-opcode flag and reset from HOLD, with hand-computed expectations.
module tb_fetch_ctrl;

  localparam logic [31:0] RESET_PC = 32'h0000_0100;

`ifdef FETCH_ILLEGAL_CHECK_EN
  localparam logic ILLEGAL_EXP = 1'b1;
`else
  localparam logic ILLEGAL_EXP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_insn;
  logic [31:0] out_pc;
  logic        out_illegal;

  int n_pass = 0;
  int n_total = 0;

  fetch_ctrl #(.RESET_PC(RESET_PC)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_insn    (out_insn),
    .out_pc      (out_pc),
    .out_illegal (out_illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Advance one rising edge and settle just after it before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, ".req"},     32'(imem_req),    32'd0);
    check({tag, ".addr"},    imem_addr,        RESET_PC);
    check({tag, ".valid"},   32'(out_valid),   32'd0);
    check({tag, ".insn"},    out_insn,         32'd0);
    check({tag, ".pc"},      out_pc,           32'd0);
    check({tag, ".illegal"}, 32'(out_illegal), 32'd0);
  endtask

  initial begin
    rst = 1'b1; imem_ack = 1'b0; imem_rdata = '0;
    redirect = 1'b0; redirect_pc = '0; out_ready = 1'b0;
    step(); step();
    check_reset_values("reset");

    // Streaming: always-ack memory, decode always ready.
    rst = 1'b0; imem_ack = 1'b1; imem_rdata = 32'h0000_0013; out_ready = 1'b1;
    step();
    check("boot.req",   32'(imem_req),  32'd1);
    check("boot.addr",  imem_addr,      32'h100);
    check("boot.valid", 32'(out_valid), 32'd0);
    for (int i = 0; i < 2; i++) begin
      step();
      check($sformatf("s%0d.valid", i), 32'(out_valid), 32'd1);
      check($sformatf("s%0d.pc", i),    out_pc,         32'h100 + 32'(i) * 4);
      check($sformatf("s%0d.insn", i),  out_insn,       32'h0000_0013);
      check($sformatf("s%0d.ill", i),   32'(out_illegal), 32'd0);
      check($sformatf("s%0d.req", i),   32'(imem_req),  32'd0);
      step();
      check($sformatf("s%0d.gap", i),   32'(out_valid), 32'd0);
      check($sformatf("s%0d.nreq", i),  32'(imem_req),  32'd1);
      check($sformatf("s%0d.addr", i),  imem_addr,      32'h104 + 32'(i) * 4);
    end

    // Stall: fetch 0x200, decode withholds ready for 5 cycles; ack stays high.
    redirect = 1'b1; redirect_pc = 32'h0000_0200; imem_ack = 1'b0; out_ready = 1'b0;
    step();
    check("r200.addr", imem_addr, 32'h200);
    redirect = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("stall%0d.valid", i), 32'(out_valid), 32'd1);
      check($sformatf("stall%0d.insn", i),  out_insn,       32'hDEAD_BEEF);
      check($sformatf("stall%0d.pc", i),    out_pc,         32'h200);
      check($sformatf("stall%0d.req", i),   32'(imem_req),  32'd0);
      check($sformatf("stall%0d.addr", i),  imem_addr,      32'h204);
    end
    out_ready = 1'b1; imem_ack = 1'b0;
    step();
    check("release.valid", 32'(out_valid), 32'd0);
    check("release.req",   32'(imem_req),  32'd1);
    check("release.addr",  imem_addr,      32'h204);

    // Redirect in FETCH with a simultaneous ack: the beat is discarded.
    redirect = 1'b1; redirect_pc = 32'h0000_0403; imem_ack = 1'b1; imem_rdata = 32'h1111_1111;
    step();
    check("rdf.valid", 32'(out_valid), 32'd0);
    check("rdf.addr",  imem_addr,      32'h400);
    check("rdf.req",   32'(imem_req),  32'd1);
    check("rdf.pc",    out_pc,         32'h200);
    redirect = 1'b0; imem_rdata = 32'h2222_2213; out_ready = 1'b0;
    step();
    check("rdf2.valid", 32'(out_valid), 32'd1);
    check("rdf2.pc",    out_pc,         32'h400);
    check("rdf2.insn",  out_insn,       32'h2222_2213);
    check("rdf2.addr",  imem_addr,      32'h404);

    // Redirect in HOLD together with a handshake.
    redirect = 1'b1; redirect_pc = 32'h0000_0800; imem_ack = 1'b0; out_ready = 1'b1;
    step();
    check("rdh.valid", 32'(out_valid), 32'd0);
    check("rdh.req",   32'(imem_req),  32'd1);
    check("rdh.addr",  imem_addr,      32'h800);

    // PC wrap at the top of the address space.
    redirect_pc = 32'hFFFF_FFFC;
    step();
    check("wrap.addr0", imem_addr, 32'hFFFF_FFFC);
    redirect = 1'b0; imem_ack = 1'b1; imem_rdata = 32'h0000_0033; out_ready = 1'b0;
    step();
    check("wrap.pc",   out_pc,         32'hFFFF_FFFC);
    check("wrap.addr", imem_addr,      32'h0);
    check("wrap.valid", 32'(out_valid), 32'd1);

    // Low opcode bits 2'b10.
    out_ready = 1'b1; imem_ack = 1'b0;
    step();
    check("ill.fetch", imem_addr, 32'h0);
    imem_ack = 1'b1; imem_rdata = 32'h0000_0012; out_ready = 1'b0;
    step();
    check("ill.insn",  out_insn,          32'h0000_0012);
    check("ill.flag",  32'(out_illegal),  32'(ILLEGAL_EXP));
    step();
    check("ill.hold",  32'(out_illegal),  32'(ILLEGAL_EXP));

    // Reset asserted mid-HOLD overrides everything.
    rst = 1'b1; out_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_0900;
    step();
    check_reset_values("rst_hold");
    rst = 1'b0; redirect = 1'b0; imem_ack = 1'b0;
    step();
    check("post.req",  32'(imem_req), 32'd1);
    check("post.addr", imem_addr,     RESET_PC);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Instruction fetch sequencer feeding the decode stage; owns the PC and the instruction-memory handshake.
- Fetches one 32-bit word at a time, holds it in an output register until decode accepts it, then advances the PC by 4.
- Handles control-flow redirects from execute.
- Sits between instruction memory and the combinational decode block. out_insn drives the decode block's insn input directly.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset; bits [1:0] must be 0.

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous reset, active-high
- imem_req  out  1  fetch request, registered
- imem_addr  out  32  fetch address (= pc), registered
- imem_ack  in  1  memory response; imem_rdata valid this cycle for the current imem_addr
- imem_rdata  in  32  fetched instruction word
- redirect  in  1  load new PC, flush held instruction
- redirect_pc  in  32  redirect target; bits [1:0] ignored
- out_valid  out  1  out_insn/out_pc valid for decode
- out_ready  in  1  decode accepts instruction
- out_insn  out  32  instruction word to decode
- out_pc  out  32  address of out_insn
- out_illegal  out  1  low opcode bits not 2'b11 (see Optional Feature)

Behaviour:
- Interface decided: one clock clk; reset rst is synchronous and active-high.
- Reset values (synchronous, rst=1 at a rising edge):
  - pc=RESET_PC, state=FETCH, imem_req=0, imem_addr=RESET_PC.
  - out_valid=0, out_insn=0, out_pc=0, out_illegal=0.
  - rst overrides every other input, including mid-fetch and mid-hold.
- States: FETCH, HOLD.
- FETCH:
  - imem_req=1 from the cycle after entry. The first cycle after reset deasserts rst with imem_req=0, then imem_req=1 on the next cycle.
  - imem_addr=pc.
  - The memory is stateless: a transfer occurs only in a cycle with imem_req=1 and imem_ack=1. There is no outstanding transaction, and imem_ack while imem_req=0 is ignored.
  - On transfer:
    - out_insn<=imem_rdata, out_pc<=pc, out_valid<=1.
    - pc<=pc+4, modulo 2^32 (32'hFFFF_FFFC wraps to 0).
    - imem_req<=0, state<=HOLD.
  - Latency: ack in cycle N gives out_valid=1 in cycle N+1.
- HOLD:
  - out_valid=1. out_insn, out_pc and out_illegal stay stable until the handshake.
  - Handshake is out_valid&out_ready:
    - out_valid<=0, state<=FETCH.
    - imem_req=1 in cycle M+1 for a handshake in cycle M.
  - Sustained throughput: 1 instruction per 2 cycles with single-cycle ack.
- Redirect (highest priority after rst), in any state:
  - pc<={redirect_pc[31:2],2'b00}, out_valid<=0, state<=FETCH.
  - imem_req<=1 and imem_addr<=new pc in the next cycle.
  - A simultaneous imem transfer is discarded: pc is not incremented and out_* is not loaded.
  - A simultaneous out handshake counts as consumed on the decode side, but the fetch path still takes the redirect.
- out_valid must never drop without a handshake, except on redirect or rst.
- imem_addr changes only on transfer, redirect or rst.
- out_ready while out_valid=0 has no effect.

Optional Feature:
- Macro: FETCH_ILLEGAL_CHECK_EN.
- Defined: out_illegal<=(imem_rdata[1:0]!=2'b11), registered alongside out_insn. The instruction is still presented and still needs a handshake; no special sequencing follows.
- Undefined: out_illegal is constant 0 and no compare logic is generated.

Test Plan:
- Reset with RESET_PC=32'h100, memory always acking with rdata=32'h0000_0013, out_ready=1 -> imem_addr sequence 0x100, 0x104, 0x108. out_pc trails by one transfer. out_valid pulses every 2nd cycle.
- Ack at 0x200, out_ready held 0 for 5 cycles -> out_valid=1 and out_insn stable for 5 cycles, imem_req=0 throughout. imem_req rises in the cycle after out_ready=1.
- Redirect to 32'h0000_0403 while in FETCH with imem_ack=1 same cycle -> word discarded, out_valid stays 0, next imem_addr=0x400, then a transfer yields out_pc=0x400.
- Redirect during HOLD with out_ready=1 same cycle -> next cycle out_valid=0, imem_req=1, imem_addr=redirect target.
- pc=32'hFFFF_FFFC, transfer -> out_pc=32'hFFFF_FFFC, next imem_addr=0.
- rdata=32'h0000_0012 with FETCH_ILLEGAL_CHECK_EN defined -> out_illegal=1. Without the macro -> out_illegal=0. Also assert rst during HOLD -> all outputs return to reset values next cycle.
